// File: rtl/conv_operand_sequencer.sv
// Operand feeder for the 1-D conv MAC: loads M weights + N samples, replays (x[i+j], w[j]) pairs; 1-cycle load->first pair, holds pair while !m_ready.
// Optional CONV_SEQ_WEIGHT_KEEP_EN: keep weights across frames (later frames load only samples).
module conv_operand_sequencer #(
  parameter int T = 14,
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [T-1:0] m_a,
  output logic [T-1:0] m_b,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_first,
  output logic         m_last,
  output logic         done
);

  localparam int AW  = (N > 1) ? $clog2(N) : 1;
  localparam int WAW = (M > 1) ? $clog2(M) : 1;
  localparam int KW  = $clog2(N + 1);
  localparam logic [AW-1:0] J_LAST   = AW'(M - 1);
  localparam logic [AW-1:0] I_LAST   = AW'(N - M);
  localparam logic [KW-1:0] K_W_LAST = KW'(M - 1);
  localparam logic [KW-1:0] K_X_LAST = KW'(N - 1);

  typedef enum logic [1:0] {LOAD_W, LOAD_X, RUN} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] i_q, i_d, j_q, j_d;
  logic [AW-1:0] ni, nj;
  logic [T-1:0]  w_q [M];
  logic [T-1:0]  w_d [M];
  logic [T-1:0]  x_q [N];
  logic [T-1:0]  x_d [N];
  logic          m_valid_q, m_valid_d;
  logic          m_first_q, m_first_d;
  logic          m_last_q, m_last_d;
  logic [T-1:0]  m_a_q, m_a_d;
  logic [T-1:0]  m_b_q, m_b_d;
  logic          done_w;

  assign done_w = (state_q == RUN) && m_valid_q && m_ready &&
                  (i_q == I_LAST) && (j_q == J_LAST);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    i_d       = i_q;
    j_d       = j_q;
    w_d       = w_q;
    x_d       = x_q;
    m_valid_d = m_valid_q;
    m_first_d = m_first_q;
    m_last_d  = m_last_q;
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    ni        = '0;
    nj        = '0;
    case (state_q)
      LOAD_W: begin
        if (s_valid) begin
          w_d[k_q[WAW-1:0]] = s_data;
          if (k_q == K_W_LAST) begin
            k_d     = '0;
            state_d = LOAD_X;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      LOAD_X: begin
        if (s_valid) begin
          x_d[k_q[AW-1:0]] = s_data;
          if (k_q == K_X_LAST) begin
            // Read x_d so the sample written this cycle is visible when N == 1.
            k_d       = '0;
            i_d       = '0;
            j_d       = '0;
            state_d   = RUN;
            m_valid_d = 1'b1;
            m_a_d     = x_d[0];
            m_b_d     = w_q[0];
            m_first_d = 1'b1;
            m_last_d  = (M == 1);
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (m_valid_q && m_ready) begin
          if (j_q == J_LAST) begin
            nj = '0;
            ni = i_q + 1'b1;
          end else begin
            nj = j_q + 1'b1;
            ni = i_q;
          end
          if (done_w) begin
            i_d       = '0;
            j_d       = '0;
            m_valid_d = 1'b0;
            m_first_d = 1'b0;
            m_last_d  = 1'b0;
            m_a_d     = '0;
            m_b_d     = '0;
`ifdef CONV_SEQ_WEIGHT_KEEP_EN
            state_d   = LOAD_X;
`else
            state_d   = LOAD_W;
`endif
          end else begin
            i_d       = ni;
            j_d       = nj;
            m_a_d     = x_q[ni + nj];
            m_b_d     = w_q[nj[WAW-1:0]];
            m_first_d = (nj == '0);
            m_last_d  = (nj == J_LAST);
          end
        end
      end
      default: state_d = LOAD_W;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD_W;
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      m_valid_q <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      m_valid_q <= m_valid_d;
      m_first_q <= m_first_d;
      m_last_q  <= m_last_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
    end
  end

  // Register files carry no reset; contents are only read after a full load.
  always_ff @(posedge clk) begin
    w_q <= w_d;
    x_q <= x_d;
  end

  assign s_ready = !reset && (state_q != RUN);
  assign m_valid = m_valid_q;
  assign m_first = m_first_q;
  assign m_last  = m_last_q;
  assign m_a     = m_a_q;
  assign m_b     = m_b_q;
  assign done    = done_w;

endmodule
